// File: rtl/span_raster.sv
// Scanline span rasteriser: walks x0..x1 on row y, emitting one pixel per cycle with interpolated depth.
// Optional build macro SPAN_CLIP_EN suppresses pixels at x >= SCREEN_W.
module span_raster #(
    parameter int XW       = 11,
    parameter int YW       = 11,
    parameter int ZW       = 16,
    parameter int FRAC     = 8,
    parameter int SCREEN_W = 640
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y,
    input  logic [ZW-1:0] z0,
    input  logic [ZW-1:0] z1,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [ZW-1:0] pix_z,
    output logic          pix_last,
    output logic          done
);

    localparam int AW = ZW + FRAC;
    localparam int CW = $clog2(AW);
    localparam logic [CW-1:0] DIV_LAST = CW'(AW - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIV, S_EMIT, S_DONE} state_t;
    state_t state, state_nx;

    logic [XW-1:0] lx0, lx1, cur_x, end_x, dx;
    logic [YW-1:0] ly;
    logic [ZW-1:0] lz0, lz1, zend;
    logic          dx_nz, dz_neg;
    logic [AW-1:0] acc, step, div_n;
    logic [XW-1:0] rem;
    logic [CW-1:0] cnt;

    logic          swap, dz_neg_w;
    logic [XW-1:0] sx0, sx1;
    logic [ZW-1:0] sz0, sz1, dz_mag;
    logic [XW:0]   trial;
    logic          q_bit;
    logic [XW-1:0] rem_nx;
    logic [AW-1:0] q_nx;
    logic          visible, last_px, advance;

    always_comb begin
        swap     = lx1 < lx0;
        sx0      = swap ? lx1 : lx0;
        sx1      = swap ? lx0 : lx1;
        sz0      = swap ? lz1 : lz0;
        sz1      = swap ? lz0 : lz1;
        dz_neg_w = sz1 < sz0;
        dz_mag   = dz_neg_w ? sz0 - sz1 : sz1 - sz0;
    end

    // Restoring divide step; quotient bits shift into the vacated low end of div_n.
    always_comb begin
        trial  = {rem, div_n[AW-1]};
        q_bit  = trial >= {1'b0, dx};
        rem_nx = q_bit ? trial[XW-1:0] - dx : trial[XW-1:0];
        q_nx   = {div_n[AW-2:0], q_bit};
    end

`ifdef SPAN_CLIP_EN
    localparam logic [XW:0] SCR    = SCREEN_W[XW:0];
    localparam logic [XW:0] SCR_M1 = SCR - 1'b1;
    // cur_x never passes end_x, so reaching SCREEN_W-1 means it is min(x1, SCREEN_W-1).
    always_comb begin
        visible = {1'b0, cur_x} < SCR;
        last_px = visible && (cur_x == end_x || {1'b0, cur_x} == SCR_M1);
    end
`else
    always_comb begin
        visible = 1'b1;
        last_px = cur_x == end_x;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        advance   = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_z     = '0;
        case (state)
            S_IDLE:  if (start) state_nx = S_SETUP;
            S_SETUP: begin
                busy     = 1'b1;
                state_nx = (sx1 == sx0) ? S_EMIT : S_DIV;
            end
            S_DIV: begin
                busy = 1'b1;
                if (cnt == DIV_LAST) state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                pix_valid = visible;
                pix_last  = last_px;
                pix_x     = cur_x;
                pix_y     = ly;
                pix_z     = (dx_nz && cur_x == end_x) ? zend : acc[AW-1:FRAC];
                advance   = visible ? pix_ready : 1'b1;
                if (advance && (last_px || cur_x == end_x)) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lx0    <= '0;
            lx1    <= '0;
            ly     <= '0;
            lz0    <= '0;
            lz1    <= '0;
            cur_x  <= '0;
            end_x  <= '0;
            dx     <= '0;
            zend   <= '0;
            dx_nz  <= 1'b0;
            dz_neg <= 1'b0;
            acc    <= '0;
            step   <= '0;
            div_n  <= '0;
            rem    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lx0 <= x0;
                    lx1 <= x1;
                    ly  <= y;
                    lz0 <= z0;
                    lz1 <= z1;
                end
                S_SETUP: begin
                    cur_x  <= sx0;
                    end_x  <= sx1;
                    dx     <= sx1 - sx0;
                    zend   <= sz1;
                    dx_nz  <= sx1 != sx0;
                    dz_neg <= dz_neg_w;
                    acc    <= {sz0, {FRAC{1'b0}}};
                    div_n  <= {dz_mag, {FRAC{1'b0}}};
                    rem    <= '0;
                    cnt    <= '0;
                    step   <= '0;
                end
                S_DIV: begin
                    rem   <= rem_nx;
                    div_n <= q_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == DIV_LAST) step <= dz_neg ? -q_nx : q_nx;
                end
                S_EMIT: if (advance) begin
                    cur_x <= cur_x + 1'b1;
                    acc   <= acc + step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_span_raster.sv
// Bench for span_raster: directed spans plus random spans against an arithmetic pixel-list model.
module tb_span_raster;

    localparam int XW       = 11;
    localparam int YW       = 11;
    localparam int ZW       = 16;
    localparam int FRAC     = 8;
    localparam int SCREEN_W = 640;
    localparam int LAT      = 2 + ZW + FRAC;

    logic          clk = 1'b0;
    logic          reset, start, pix_ready;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y;
    logic [ZW-1:0] z0, z1;
    logic          busy, pix_valid, pix_last, done;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [ZW-1:0] pix_z;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    span_raster #(.XW(XW), .YW(YW), .ZW(ZW), .FRAC(FRAC), .SCREEN_W(SCREEN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y(y), .z0(z0), .z1(z1),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z), .pix_last(pix_last), .done(done)
    );

    typedef struct {
        int x;
        int y;
        int z;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    int   exp_lat;
    bit   lat_check;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pixel list straight from the interpolation rules.
    function automatic void build_expected(input int ax0, input int ax1, input int ay,
                                           input int az0, input int az1);
        int     sx0, sx1, sz0, sz1, dx, dz, lim;
        longint q, st, a;
        pix_t   p;
        exp_q.delete();
        if (ax1 < ax0) begin
            sx0 = ax1; sx1 = ax0; sz0 = az1; sz1 = az0;
        end else begin
            sx0 = ax0; sx1 = ax1; sz0 = az0; sz1 = az1;
        end
        dx  = sx1 - sx0;
        dz  = sz1 - sz0;
        q   = (dx == 0) ? 0 : (longint'(dz < 0 ? -dz : dz) * 256) / dx;
        st  = (dz < 0) ? -q : q;
        lim = sx1;
`ifdef SPAN_CLIP_EN
        if (lim > SCREEN_W - 1) lim = SCREEN_W - 1;
`endif
        for (int i = 0; i <= dx; i++) begin
            p.x = sx0 + i;
            p.y = ay;
            if (dx == 0)       p.z = sz0;
            else if (i == dx)  p.z = sz1;
            else begin
                a   = longint'(sz0) * 256 + i * st;
                p.z = int'(a / 256);
            end
            p.last = (p.x == lim);
            if (p.x <= lim) exp_q.push_back(p);
        end
        exp_lat   = (dx == 0) ? 2 : LAT;
        lat_check = (exp_q.size() > 0) && (exp_q[0].x == sx0);
    endfunction

    // rmode: 0 ready always high, 1 random ready, 2 ready 1,0,0,1 then high (per valid cycle).
    task automatic run_span(input int ax0, input int ax1, input int ay, input int az0,
                            input int az1, input int rmode, input bit poke);
        pix_t e, h;
        bit   held, fin, first_seen;
        int   cyc, last_xfer, pidx;
        bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        build_expected(ax0, ax1, ay, az0, az1);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        x0 = XW'(ax0); x1 = XW'(ax1); y = YW'(ay); z0 = ZW'(az0); z1 = ZW'(az1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; held = 0; fin = 0; first_seen = 0; last_xfer = -1; pidx = 0;
        while (!fin && cyc < 10000) begin
            if (poke && cyc == 4 && ax0 != ax1) begin
                start = 1'b1;
                x0 = XW'($urandom); x1 = XW'($urandom); y = YW'($urandom);
                z0 = ZW'($urandom); z1 = ZW'($urandom);
            end else start = 1'b0;
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = (pidx < 4) ? pat[pidx] : 1'b1;
            endcase
            if (held) begin
                chk("stall_valid", 64'(pix_valid), 64'(1));
                chk("stall_x", 64'(pix_x), 64'(h.x));
                chk("stall_y", 64'(pix_y), 64'(h.y));
                chk("stall_z", 64'(pix_z), 64'(h.z));
                chk("stall_last", 64'(pix_last), 64'(h.last));
            end
            if (done) begin
                chk("done_busy", 64'(busy), 64'(0));
                chk("pixels_left", 64'(exp_q.size()), 64'(0));
                if (last_xfer >= 0) chk("done_cycle", 64'(cyc), 64'(last_xfer + 1));
                fin = 1;
            end else begin
                chk("busy", 64'(busy), 64'(1));
                if (pix_valid) begin
                    if (!first_seen && lat_check) chk("first_valid_cycle", 64'(cyc), 64'(exp_lat));
                    first_seen = 1;
                    if (pix_ready) begin
                        if (exp_q.size() == 0) chk("extra_pixel", 64'(pix_valid), 64'(0));
                        else begin
                            e = exp_q.pop_front();
                            chk("pix_x", 64'(pix_x), 64'(e.x));
                            chk("pix_y", 64'(pix_y), 64'(e.y));
                            chk("pix_z", 64'(pix_z), 64'(e.z));
                            chk("pix_last", 64'(pix_last), 64'(e.last));
                        end
                        last_xfer = cyc;
                        held = 0;
                    end else begin
                        held = 1;
                        h.x = int'(pix_x); h.y = int'(pix_y); h.z = int'(pix_z); h.last = pix_last;
                    end
                    pidx++;
                end else held = 0;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("span_finished", 64'(fin), 64'(1));
        start = 1'b0;
    endtask

    initial begin
        int  n;
        bit  saw_bad;
        int  rx0, rx1;

        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x0 = '0; x1 = '0; y = '0; z0 = '0; z1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(pix_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_x", 64'(pix_x), 64'(0));
        chk("rst_z", 64'(pix_z), 64'(0));
        reset = 1'b0;

        run_span(10, 13, 4, 0, 300, 0, 0);
        run_span(13, 10, 4, 300, 0, 0, 0);
        run_span(5, 5, 9, 7, 9, 0, 0);
        run_span(0, 2, 1, 10, 0, 2, 0);

        // Reset on the second EMIT cycle of a 0..7 span.
        @(negedge clk);
        x0 = XW'(0); x1 = XW'(7); y = YW'(3); z0 = ZW'(100); z1 = ZW'(800);
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_reached_emit", 64'(pix_valid), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_valid", 64'(pix_valid), 64'(0));
        chk("midrst_x", 64'(pix_x), 64'(0));
        chk("midrst_y", 64'(pix_y), 64'(0));
        chk("midrst_z", 64'(pix_z), 64'(0));
        chk("midrst_last", 64'(pix_last), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        saw_bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || pix_valid || busy) saw_bad = 1;
        end
        chk("midrst_quiet", 64'(saw_bad), 64'(0));

        run_span(0, 7, 3, 100, 800, 0, 0);
        run_span(637, 642, 20, 1000, 2000, 1, 0);
        run_span(700, 710, 21, 5, 50000, 0, 0);
        run_span(0, 2047, 2, 65535, 0, 1, 0);
        run_span(2047, 2046, 7, 0, 65535, 0, 0);

        for (int k = 0; k < 14; k++) begin
            rx0 = $urandom_range(0, 60);
            rx1 = ($urandom_range(0, 3) == 0) ? rx0 : $urandom_range(0, 60);
            run_span(rx0, rx1, $urandom_range(0, 2047), $urandom_range(0, 65535),
                     $urandom_range(0, 65535), 1, 1);
        end

        @(negedge clk);
        chk("final_done_low", 64'(done), 64'(0));
        chk("final_busy_low", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation still running, limit 5000000");
        $fatal(1, "global timeout");
    end

endmodule
